// File: rtl/apb_arb_pkg.sv
// Shared types and default sizing for the two-requester APB master.
package apb_arb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  localparam int unsigned AW_DEFAULT      = 9;
  localparam int unsigned DW_DEFAULT      = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered tie-break pointer.
module apb_rr_arb2 (
  input  logic       pclk,
  input  logic       presetn,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  input  logic       i_update,
  output logic [1:0] o_gnt
);

  logic       prio_q;  // requester that wins when both are eligible
  logic [1:0] eligible;

  always_comb begin
    eligible = i_req & ~i_mask;
    o_gnt    = eligible;
    if (eligible == 2'b11) begin
      o_gnt = prio_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prio_q <= 1'b0;
    end else if (i_update && (o_gnt != 2'b00)) begin
      prio_q <= o_gnt[0];
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters; round-robin arbitration, wait states and ACCESS timeout.
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int unsigned AW      = AW_DEFAULT,
  parameter int unsigned DW      = DW_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic [1:0]    i_req,
  input  logic [1:0]    i_write,
  input  logic [AW-1:0] i_addr  [2],
  input  logic [DW-1:0] i_wdata [2],
  output logic [1:0]    o_done,
  output logic [DW-1:0] o_rdata,
  output logic          o_err,
  output logic [AW-1:0] o_paddr,
  output logic [DW-1:0] o_pwdata,
  output logic          o_pwrite,
  output logic [1:0]    o_psel,
  output logic          o_penable,
  input  logic [DW-1:0] i_prdata,
  input  logic          i_pready,
  input  logic          i_pslverr
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  apb_state_e    state_q;
  logic          gidx_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    gnt;
  logic          gidx;

  // A requester completing this cycle is masked so its still-high i_req is not re-granted.
  apb_rr_arb2 u_arb (
    .pclk     (pclk),
    .presetn  (presetn),
    .i_req    (i_req),
    .i_mask   (o_done),
    .i_update (state_q == IDLE),
    .o_gnt    (gnt)
  );

  assign gidx = gnt[1];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      gidx_q    <= 1'b0;
      cnt_q     <= '0;
      o_done    <= 2'b00;
      o_rdata   <= '0;
      o_err     <= 1'b0;
      o_paddr   <= '0;
      o_pwdata  <= '0;
      o_pwrite  <= 1'b0;
      o_psel    <= 2'b00;
      o_penable <= 1'b0;
    end else begin
      o_done <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (gnt != 2'b00) begin
            gidx_q   <= gidx;
            o_paddr  <= i_addr[gidx];
            o_pwdata <= i_wdata[gidx];
            o_pwrite <= i_write[gidx];
            o_psel   <= i_addr[gidx][AW-1] ? 2'b10 : 2'b01;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          o_penable <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (i_pready || (cnt_q == CW'(TIMEOUT - 1))) begin
            // Timeout is only reached with i_pready low, so it reports an error and no data.
            o_done    <= gidx_q ? 2'b10 : 2'b01;
            o_err     <= i_pready ? i_pslverr : 1'b1;
            o_rdata   <= (i_pready && !o_pwrite) ? i_prdata : '0;
            o_psel    <= 2'b00;
            o_penable <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: transfers, wait states, timeout, errors, arbitration, reset.
module tb_apb_arb_master;

  logic       pclk = 1'b0;
  logic       presetn;
  logic [1:0] i_req;
  logic [1:0] i_write;
  logic [8:0] i_addr  [2];
  logic [7:0] i_wdata [2];
  logic [1:0] o_done;
  logic [7:0] o_rdata;
  logic       o_err;
  logic [8:0] o_paddr;
  logic [7:0] o_pwdata;
  logic       o_pwrite;
  logic [1:0] o_psel;
  logic       o_penable;
  logic [7:0] i_prdata;
  logic       i_pready;
  logic       i_pslverr;

  int passed = 0;
  int total  = 0;

  always #5 pclk = ~pclk;

  apb_arb_master #(.AW(9), .DW(8), .TIMEOUT(16)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_req     (i_req),
    .i_write   (i_write),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .o_done    (o_done),
    .o_rdata   (o_rdata),
    .o_err     (o_err),
    .o_paddr   (o_paddr),
    .o_pwdata  (o_pwdata),
    .o_pwrite  (o_pwrite),
    .o_psel    (o_psel),
    .o_penable (o_penable),
    .i_prdata  (i_prdata),
    .i_pready  (i_pready),
    .i_pslverr (i_pslverr)
  );

  task automatic test_reset();
    presetn = 1'b0;
    i_req = 2'b00; i_write = 2'b00; i_prdata = 8'h00; i_pready = 1'b0; i_pslverr = 1'b0;
    i_addr[0] = 9'h000; i_addr[1] = 9'h000; i_wdata[0] = 8'h00; i_wdata[1] = 8'h00;
    repeat (2) @(negedge pclk);
    total++; if (o_psel !== 2'b00) $display("FAIL reset_psel: got %b want 00", o_psel);
    else passed++;
    total++; if (o_penable !== 1'b0) $display("FAIL reset_penable: got %b want 0", o_penable);
    else passed++;
    total++; if (o_done !== 2'b00) $display("FAIL reset_done: got %b want 00", o_done);
    else passed++;
    total++;
    if ({o_rdata, o_err, o_paddr, o_pwdata, o_pwrite} !== '0)
      $display("FAIL reset_data: got %h want 0", {o_rdata, o_err, o_paddr, o_pwdata, o_pwrite});
    else passed++;
    presetn = 1'b1;
  endtask

  task automatic test_write0();
    @(negedge pclk);
    i_req = 2'b01; i_write = 2'b01; i_addr[0] = 9'h005; i_wdata[0] = 8'hA5;
    i_pready = 1'b1; i_pslverr = 1'b0; i_prdata = 8'h77;
    @(negedge pclk);
    total++; if (o_psel !== 2'b01 || o_penable !== 1'b0)
      $display("FAIL wr_setup: got psel=%b pen=%b want 01/0", o_psel, o_penable);
    else passed++;
    total++; if (o_paddr !== 9'h005 || o_pwdata !== 8'hA5 || o_pwrite !== 1'b1)
      $display("FAIL wr_cmd: got %h/%h/%b want 005/a5/1", o_paddr, o_pwdata, o_pwrite);
    else passed++;
    @(negedge pclk);
    total++; if (o_psel !== 2'b01 || o_penable !== 1'b1)
      $display("FAIL wr_access: got psel=%b pen=%b want 01/1", o_psel, o_penable);
    else passed++;
    @(negedge pclk);
    total++; if (o_done !== 2'b01 || o_err !== 1'b0 || o_rdata !== 8'h00 || o_psel !== 2'b00)
      $display("FAIL wr_done: got done=%b err=%b rdata=%h psel=%b want 01/0/00/00",
               o_done, o_err, o_rdata, o_psel);
    else passed++;
    // Request still held through the done cycle: must not be granted again.
    @(negedge pclk);
    total++; if (o_psel !== 2'b00 || o_done !== 2'b00)
      $display("FAIL wr_no_regrant: got psel=%b done=%b want 00/00", o_psel, o_done);
    else passed++;
    i_req = 2'b00;
    @(negedge pclk);
  endtask

  task automatic test_read1_waits();
    int acc = 0;
    int seen = 0;
    logic [1:0] psel_acc = 2'b00;
    @(negedge pclk);
    i_req = 2'b10; i_write = 2'b00; i_addr[1] = 9'h105; i_pready = 1'b0; i_prdata = 8'h3C;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge pclk);
      if (o_done !== 2'b00) seen = 1;
      else begin
        if (o_penable) begin acc++; psel_acc = o_psel; end
        i_pready = (acc >= 3);
      end
    end
    total++; if (seen == 0) $display("FAIL rd_timeout_wait: got no done want done");
    else passed++;
    total++; if (acc != 3) $display("FAIL rd_access_len: got %0d want 3", acc);
    else passed++;
    total++; if (psel_acc !== 2'b10) $display("FAIL rd_psel: got %b want 10", psel_acc);
    else passed++;
    total++; if (o_done !== 2'b10 || o_rdata !== 8'h3C || o_err !== 1'b0)
      $display("FAIL rd_done: got done=%b rdata=%h err=%b want 10/3c/0", o_done, o_rdata, o_err);
    else passed++;
    i_req = 2'b00; i_pready = 1'b0; i_prdata = 8'h99;
    repeat (3) @(negedge pclk);
    total++; if (o_rdata !== 8'h3C || o_done !== 2'b00 || o_paddr !== 9'h105)
      $display("FAIL rd_hold: got rdata=%h done=%b paddr=%h want 3c/00/105",
               o_rdata, o_done, o_paddr);
    else passed++;
  endtask

  // ready_at = ACCESS cycle in which i_pready rises (0 = never).
  task automatic test_timeout(input int ready_at, input logic exp_err, input logic [7:0] exp_rd,
                              input int exp_len);
    int acc = 0;
    int seen = 0;
    @(negedge pclk);
    i_req = 2'b01; i_write = 2'b00; i_addr[0] = 9'h00A; i_pready = 1'b0; i_prdata = 8'hE7;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      @(negedge pclk);
      if (o_done !== 2'b00) seen = 1;
      else begin
        if (o_penable) acc++;
        i_pready = (ready_at != 0) && (acc >= ready_at);
      end
    end
    total++; if (seen == 0) $display("FAIL to_wait: got no done want done");
    else passed++;
    total++; if (acc != exp_len) $display("FAIL to_len: got %0d want %0d", acc, exp_len);
    else passed++;
    total++; if (o_done !== 2'b01 || o_err !== exp_err || o_rdata !== exp_rd || o_psel !== 2'b00)
      $display("FAIL to_result: got done=%b err=%b rdata=%h psel=%b want 01/%b/%h/00",
               o_done, o_err, o_rdata, o_psel, exp_err, exp_rd);
    else passed++;
    i_req = 2'b00; i_pready = 1'b0;
    @(negedge pclk);
  endtask

  task automatic test_slverr();
    for (int k = 0; k < 2; k++) begin
      @(negedge pclk);
      i_req = 2'b01; i_write = 2'b01; i_addr[0] = 9'h033; i_wdata[0] = 8'h5A;
      i_pready = 1'b1; i_pslverr = (k == 0);
      repeat (3) @(negedge pclk);
      total++; if (o_done !== 2'b01 || o_err !== (k == 0) || o_rdata !== 8'h00)
        $display("FAIL slverr_%0d: got done=%b err=%b rdata=%h want 01/%0d/00",
                 k, o_done, o_err, o_rdata, (k == 0));
      else passed++;
      i_req = 2'b00; i_pslverr = 1'b0;
    end
    @(negedge pclk);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int dbl = 0;
    int at [4];
    logic [1:0] d [4];
    presetn = 1'b0;
    i_req = 2'b11; i_write = 2'b00; i_addr[0] = 9'h011; i_addr[1] = 9'h111; i_pready = 1'b1;
    @(negedge pclk);
    presetn = 1'b1;
    for (int c = 1; c <= 30 && n < 4; c++) begin
      @(negedge pclk);
      if (o_psel === 2'b11) dbl++;
      if (o_done !== 2'b00) begin
        at[n] = c; d[n] = o_done; n++;
        if (n == 4) i_req = 2'b00;
      end
    end
    total++; if (n != 4) $display("FAIL b2b_count: got %0d want 4", n);
    else passed++;
    total++; if (dbl != 0) $display("FAIL b2b_double_sel: got %0d want 0", dbl);
    else passed++;
    if (n == 4) begin
      total++;
      if (d[0] !== 2'b01 || d[1] !== 2'b10 || d[2] !== 2'b01 || d[3] !== 2'b10)
        $display("FAIL b2b_order: got %b %b %b %b want 01 10 01 10", d[0], d[1], d[2], d[3]);
      else passed++;
      total++; if (at[0] != 3 || at[1] != 6 || at[2] != 9 || at[3] != 12)
        $display("FAIL b2b_timing: got %0d %0d %0d %0d want 3 6 9 12",
                 at[0], at[1], at[2], at[3]);
      else passed++;
    end
    @(negedge pclk);
  endtask

  task automatic test_mid_reset();
    int hit = 0;
    int spur = 0;
    @(negedge pclk);
    i_req = 2'b01; i_write = 2'b00; i_addr[0] = 9'h00C; i_addr[1] = 9'h10C; i_pready = 1'b0;
    for (int c = 0; c < 10 && hit == 0; c++) begin
      @(negedge pclk);
      if (o_penable) hit = 1;
    end
    total++; if (hit == 0) $display("FAIL mr_reach_access: got no access want access");
    else passed++;
    #2 presetn = 1'b0;
    #1;
    total++; if (o_psel !== 2'b00 || o_penable !== 1'b0 || o_done !== 2'b00 || o_paddr !== '0)
      $display("FAIL mr_async: got psel=%b pen=%b done=%b paddr=%h want 00/0/00/000",
               o_psel, o_penable, o_done, o_paddr);
    else passed++;
    i_req = 2'b11; i_pready = 1'b1;
    repeat (2) begin
      @(negedge pclk);
      if (o_done !== 2'b00) spur++;
    end
    presetn = 1'b1;
    @(negedge pclk);
    if (o_done !== 2'b00) spur++;
    total++; if (spur != 0) $display("FAIL mr_no_done: got %0d pulses want 0", spur);
    else passed++;
    total++; if (o_psel !== 2'b01 || o_paddr !== 9'h00C)
      $display("FAIL mr_first_grant: got psel=%b paddr=%h want 01/00c", o_psel, o_paddr);
    else passed++;
    i_req = 2'b00;
    repeat (3) @(negedge pclk);
  endtask

  initial begin
    test_reset();
    test_write0();
    test_read1_waits();
    test_timeout(0, 1'b1, 8'h00, 16);
    test_timeout(16, 1'b0, 8'hE7, 16);
    test_slverr();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 SHALL have parameter AW, default 9: address width; bit AW-1 selects the slave.
REQ-002 SHALL have parameter DW, default 8: data width.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles before forced termination (TIMEOUT >= 2).
REQ-004 SHALL have port pclk, input, 1: the single clock; all logic rises on posedge.
REQ-005 SHALL have port presetn, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port i_req, input, [1:0]: per-requester transfer request, held until that requester's o_done.
REQ-007 SHALL have port i_write, input, [1:0]: per-requester direction (1 = write).
REQ-008 SHALL have ports i_addr [2][AW] and i_wdata [2][DW], inputs: per-requester command; stable while i_req is high.
REQ-009 SHALL have port o_done, output, [1:0]: one-cycle completion pulse per requester.
REQ-010 SHALL have ports o_rdata [DW] and o_err [1], outputs: result of the completing transfer; valid with o_done.
REQ-011 SHALL have APB outputs o_paddr [AW], o_pwdata [DW], o_pwrite [1], o_psel [1:0] and o_penable [1].
REQ-012 SHALL have APB inputs i_prdata [DW], i_pready [1] and i_pslverr [1].

Function
REQ-013 SHALL implement the FSM states IDLE, SETUP and ACCESS.
REQ-014 SHALL take IDLE->SETUP when any unmasked request is present; SETUP->ACCESS is unconditional; ACCESS->IDLE occurs on i_pready=1 or on timeout. ACCESS never goes directly to SETUP.
REQ-015 IDLE arbitration SHALL be round-robin: a single request is granted; with both requesting, the requester not granted last wins; after reset requester 0 wins.
REQ-016 In IDLE, a requester whose o_done is high in that cycle SHALL be masked from arbitration, so a held i_req for a finished transfer is never re-granted.
REQ-017 On grant, the design SHALL register the command (addr, wdata, write, grant index); o_paddr, o_pwdata and o_pwrite SHALL then be stable from SETUP through ACCESS and hold their last values in IDLE.
REQ-018 o_psel SHALL be one-hot in SETUP/ACCESS: bit 0 when addr[AW-1]=0, bit 1 otherwise; 2'b00 in IDLE.
REQ-019 o_penable SHALL be 1 only in ACCESS.
REQ-020 A 0-wait slave SHALL give exactly one SETUP cycle plus one ACCESS cycle; each wait state (i_pready=0) SHALL extend ACCESS by one cycle.
REQ-021 o_done[g] SHALL be registered and pulse for one cycle, the cycle after the terminating ACCESS cycle.
REQ-022 With that pulse, o_err SHALL equal i_pslverr and o_rdata SHALL equal i_prdata for reads, both sampled at the terminating edge; for writes, o_rdata SHALL equal 0.
REQ-023 o_rdata and o_err SHALL hold until the next completion.
REQ-024 The ACCESS counter SHALL reset on entry to ACCESS; if ACCESS reaches its TIMEOUT-th cycle with i_pready=0, the transfer SHALL terminate with o_done[g]=1, o_err=1 and o_rdata=0.
REQ-025 i_pready=1 in the TIMEOUT-th cycle SHALL count as a normal completion.

Reset
REQ-026 presetn low SHALL immediately force the FSM to IDLE, the round-robin pointer to favour requester 0, every output to 0 and the counter to 0.
REQ-027 A transfer in flight at reset SHALL be discarded with no o_done.
REQ-028 After presetn rises, the first grant SHALL occur no earlier than the first posedge.

Structure
REQ-029 Package apb_arb_pkg SHALL hold the state enum typedef (IDLE/SETUP/ACCESS) and the AW/DW/TIMEOUT default constants.
REQ-030 Arbitration SHALL be sub-module apb_rr_arb2 (2-way round-robin: req[1:0], mask[1:0], update strobe -> one-hot gnt[1:0], registered last-grant pointer).

Verification
REQ-031 Requester 0 write, addr 9'h005, data 8'hA5, i_pready=1 -> o_psel=01 for 2 cycles, o_penable in the 2nd, o_done=01 next cycle, o_err=0.
REQ-032 Requester 1 read, addr 9'h105, slave returns 8'h3C after 2 wait states -> o_psel=10, ACCESS lasts 3 cycles, o_rdata=8'h3C with o_done=10.
REQ-033 Both i_req held high from reset, 0-wait slave -> grant order 0,1,0,1; o_done alternates 01/10 every 3 cycles; no double grant.
REQ-034 i_pready stuck 0 -> ACCESS lasts exactly 16 cycles, then o_done with o_err=1, o_rdata=0, o_psel=00.
REQ-035 i_pslverr=1 with i_pready=1 on a write -> o_err=1 with o_done; the next transfer completes with o_err=0.
REQ-036 presetn pulsed low mid-ACCESS -> all outputs 0 asynchronously, no o_done; after release, with both requesting, requester 0 is granted first.
